// File: rtl/apb_rr_master_arbiter_pkg.sv
// Shared types for the round-robin APB master arbiter: FSM states, the
// latched request and response-error codes.
package apb_rr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Fields are sized for the widest supported build; the arbiter slices
    // them down to its own APB_ADDR_WIDTH / APB_DATA_WIDTH / pointer width.
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_IDX_W  = 8;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic                  write;
        logic [MAX_DATA_W-1:0] wdata;
        logic [MAX_IDX_W-1:0]  idx;
    } req_lat_t;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/apb_rr_master_arbiter_if.sv
// Requester channels plus the APB master bus; the arbiter takes the master
// modport, the requesters/peripheral side takes the slave modport.
interface apb_rr_master_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                req_valid_i;
    logic [NUM_REQ-1:0]                req_ready_o;
    logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ-1:0]                req_write_i;
    logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]                rsp_valid_o;
    logic [APB_DATA_WIDTH-1:0]         rsp_rdata_o;
    logic                              rsp_err_o;
    logic [APB_ADDR_WIDTH-1:0]         paddr_o;
    logic                              psel_o;
    logic                              penable_o;
    logic                              pwrite_o;
    logic [APB_DATA_WIDTH-1:0]         pwdata_o;
    logic [APB_DATA_WIDTH-1:0]         prdata_i;
    logic                              pready_i;
    logic                              pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
    );
endinterface

// File: rtl/apb_rr_master_arbiter_rr_pick.sv
// Combinational round-robin select: first valid requester at or after the
// pointer, wrapping modulo NUM_REQ (also for non-power-of-2 counts).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);
    logic [PTR_W:0] slot;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        slot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = {1'b0, ptr} + (PTR_W+1)'(i);
            if (slot >= (PTR_W+1)'(NUM_REQ))
                slot = slot - (PTR_W+1)'(NUM_REQ);
            if (!any && valid[slot[PTR_W-1:0]]) begin
                any                     = 1'b1;
                grant[slot[PTR_W-1:0]] = 1'b1;
                idx                     = slot[PTR_W-1:0];
            end
        end
    end
endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing and an ACCESS-phase timeout.
module apb_rr_master_arbiter
    import apb_rr_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                     clk_i,
    input logic                     rst_i,
    apb_rr_master_arbiter_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    state_t                    state;
    logic [PTR_W-1:0]          ptr;
    logic [CNT_W-1:0]          tmo_cnt;
    req_lat_t                  lat;
    logic                      psel_q;
    logic                      penable_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;

    logic [NUM_REQ-1:0]        grant_oh;
    logic [PTR_W-1:0]          grant_idx;
    logic                      any_valid;
    logic                      handshake;
    logic                      tmo_hit;
    logic [PTR_W-1:0]          cur_idx;
    logic [NUM_REQ-1:0]        rsp_oh;
    logic                      unused_lat;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .valid (bus.req_valid_i),
        .ptr   (ptr),
        .grant (grant_oh),
        .idx   (grant_idx),
        .any   (any_valid)
    );

    // Ready is combinational in IDLE, so gate it with reset to keep outputs low.
    assign handshake = (state == ST_IDLE) && any_valid && !rst_i;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    assign cur_idx   = lat.idx[PTR_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            tmo_cnt   <= '0;
            lat       <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= RSP_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        lat.addr  <= MAX_ADDR_W'(bus.req_addr_i[grant_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]);
                        lat.write <= bus.req_write_i[grant_idx];
                        lat.wdata <= MAX_DATA_W'(bus.req_wdata_i[grant_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH]);
                        lat.idx   <= MAX_IDX_W'(grant_idx);
                        psel_q    <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready wins over a timeout expiring in the same cycle
                    if (bus.pready_i) begin
                        rdata_q   <= lat.write ? '0 : bus.prdata_i;
                        err_q     <= bus.pslverr_i;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state     <= ST_RESP;
                    end else if (tmo_hit) begin
                        rdata_q   <= '0;
                        err_q     <= RSP_ERR;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    ptr     <= (cur_idx == PTR_LAST) ? '0 : cur_idx + 1'b1;
                    tmo_cnt <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_oh = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_oh[i] = (state == ST_RESP) && (cur_idx == PTR_W'(i));
    end

    assign bus.req_ready_o = handshake ? grant_oh : '0;
    assign bus.rsp_valid_o = rsp_oh;
    assign bus.rsp_rdata_o = (state == ST_RESP) ? rdata_q : '0;
    assign bus.rsp_err_o   = (state == ST_RESP) ? err_q : RSP_OK;
    assign bus.paddr_o     = lat.addr[APB_ADDR_WIDTH-1:0];
    assign bus.pwrite_o    = lat.write;
    assign bus.pwdata_o    = lat.wdata[APB_DATA_WIDTH-1:0];
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;

    // Upper bits of the wide latch struct are never driven nonzero.
    assign unused_lat = ^lat;
endmodule

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ on-chip requesters, for example the AXI-to-APB bridge and debug/config engines.
- Each requester uses a simple valid/ready request channel and a one-cycle response strobe.
- The block runs APB SETUP/ACCESS sequencing, round-robin arbitration and an ACCESS-phase timeout.
- It sits between the requesters and the peripheral APB bus.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- APB_ADDR_WIDTH, 12, PADDR width.
- APB_DATA_WIDTH, 32, PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 16, ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_addr_i  in  NUM_REQ*APB_ADDR_WIDTH  packed addresses; requester k at slice k.
- req_write_i  in  NUM_REQ  1 = write.
- req_wdata_i  in  NUM_REQ*APB_DATA_WIDTH  packed write data.
- rsp_valid_o  out  NUM_REQ  one-cycle response strobe (one-hot or zero).
- rsp_rdata_o  out  APB_DATA_WIDTH  read data, shared by all requesters.
- rsp_err_o  out  1  error flag (PSLVERR or timeout), shared.
- paddr_o  out  APB_ADDR_WIDTH  APB address.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  APB_DATA_WIDTH  APB write data.
- prdata_i  in  APB_DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE, round-robin pointer 0, timeout counter 0.
  - Asserting rst_i mid-transfer drops the transfer immediately. No response is issued and psel_o falls asynchronously.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Grant index k is the first requester with req_valid_i set, searching pointer, pointer+1, ... modulo NUM_REQ.
  - req_ready_o[k] is asserted combinationally in the same cycle.
  - On handshake, latch address, write and wdata of slice k plus index k, then go to SETUP.
  - With no valid request, stay in IDLE with req_ready_o = 0.
  - req_ready_o is 0 in every other state.
- SETUP: psel_o=1, penable_o=0, paddr/pwrite/pwdata from the latched values. Exactly one cycle, then ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1, APB outputs held stable.
  - On pready_i=1: capture prdata_i (forced to 0 for writes) and pslverr_i, then go to RESP.
  - Timeout: the counter increments each ACCESS cycle with pready_i=0. If it reaches TIMEOUT_CYCLES-1 while pready_i=0, abort: err=1, rdata=0, go to RESP.
  - pready_i has priority over timeout in the same cycle.
- RESP:
  - psel_o=0, penable_o=0.
  - rsp_valid_o[k]=1 for exactly one cycle; requesters have no backpressure.
  - rsp_rdata_o and rsp_err_o are valid only while any rsp_valid_o bit is high, and are 0 otherwise.
  - Pointer becomes (k+1) mod NUM_REQ; counter clears; go to IDLE.
- Latency:
  - Handshake at cycle t, SETUP t+1, ACCESS t+2.
  - With zero wait states: rsp_valid at t+3, next grant at t+4.
  - Each wait state adds 1 cycle.
- Requests that drop after handshake do not affect the transfer. Input slices of ungranted requesters are ignored.
- Pointer width is $clog2(NUM_REQ). Wrap-around from NUM_REQ-1 goes to 0, including for non-power-of-2 NUM_REQ.
- psel_o and penable_o are registered outputs; the APB outputs never glitch between SETUP and ACCESS.

Decomposition:
- Package apb_rr_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the latched-request struct (addr, write, wdata, idx);
  - the response-error localparams.
- Sub-module rr_pick: combinational round-robin priority select. It takes NUM_REQ valids plus the pointer and returns a one-hot grant, an index and an any-valid flag.

Test Plan:
- Single read, no wait:
  - Stimulus: req 2 valid, addr 0x10; slave returns pready at the first ACCESS cycle, prdata 0xDEADBEEF.
  - Response: req_ready_o=0b0100 at t; psel at t+1; penable at t+2; rsp_valid_o=0b0100 at t+3 with rdata 0xDEADBEEF, err 0.
- Contention:
  - Stimulus: all 4 requesters held valid from reset.
  - Response: grant order 0,1,2,3,0; each transfer 4 cycles apart with zero wait states.
- Wait states:
  - Stimulus: write from req 1, wdata 0xA5A5A5A5; pready delayed 3 cycles.
  - Response: paddr/pwdata/pwrite stable for 4 ACCESS cycles; rsp_valid_o=0b0010 at t+6; rdata 0.
- Slave error:
  - Stimulus: pready=1 with pslverr=1 on a read from req 3.
  - Response: rsp_err_o=1 with rsp_valid_o=0b1000; pointer moves to 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, pready held 0.
  - Response: abort after the 16th ACCESS cycle; rsp_err_o=1, rdata 0; psel drops; next request granted normally.
- Reset mid-ACCESS:
  - Stimulus: assert rst_i during a wait-state cycle.
  - Response: psel/penable fall asynchronously; no rsp_valid; after release, req 0 has priority.
